pulse_seq_ctrl: RTL

- Clocked controller that sequences the two-bit pulse-mode sequence-detector datapath (inputs x and rd; state y2/y1; output z) on the EGO1 board.
- Holds the detector in clear (rd low), then issues a programmed train of x pulses separated by programmable gaps.
- Counts z rising edges and captures the detector state after each pulse.
- Sits between board switches/buttons and the detector instance; replaces hand-timed stimulus.

---
 rtl/pulse_seq_ctrl_if.sv | 27 ++
 rtl/pulse_seq_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pulse_seq_ctrl_if.sv
// Control and detector-side signals of the pulse sequence controller.
// The master side drives run parameters and detector feedback; the slave is the controller.
interface pulse_seq_ctrl_if #(
    parameter int unsigned GAP_BITS = 16
) ();
    logic                start;
    logic [7:0]          num_pulses;
    logic [GAP_BITS-1:0] gap;
    logic                z_in;
    logic [1:0]          y_in;
    logic                x_out;
    logic                rd_n;
    logic                busy;
    logic                done;
    logic [7:0]          z_count;
    logic [1:0]          last_state;

    modport master (
        output start, num_pulses, gap, z_in, y_in,
        input  x_out, rd_n, busy, done, z_count, last_state
    );

    modport slave (
        input  start, num_pulses, gap, z_in, y_in,
        output x_out, rd_n, busy, done, z_count, last_state
    );
endinterface

// File: rtl/pulse_seq_ctrl.sv
// Sequences clear/pulse/gap stimulus for the two-bit pulse-mode sequence detector,
// counts synchronized z rising edges and captures detector state after each pulse.
module pulse_seq_ctrl #(
    parameter int unsigned PULSE_W  = 5,
    parameter int unsigned CLR_CYC  = 5,
    parameter int unsigned GAP_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    pulse_seq_ctrl_if.slave  bus
);
    localparam int unsigned PW_BITS  = $clog2(PULSE_W + 1);
    localparam int unsigned CLR_BITS = $clog2(CLR_CYC + 1);
    localparam int unsigned FIX_BITS = (PW_BITS > CLR_BITS) ? PW_BITS : CLR_BITS;
    localparam int unsigned CNT_W    = (GAP_BITS > FIX_BITS) ? GAP_BITS : FIX_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_HIGH,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          pulse_q, pulse_d;
    logic [7:0]          num_q, num_d;
    logic [GAP_BITS-1:0] gap_q, gap_d;
    logic [1:0]          last_state_q, last_state_d;
    logic [7:0]          z_count_q, z_count_d;
    logic                z_meta_q, z_meta_d;
    logic                z_s_q, z_s_d;
    logic                z_dly_q, z_dly_d;
    logic                x_out_q, x_out_d;
    logic                rd_n_q, rd_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                z_rise;

    // Next-state, counters and registered output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pulse_d      = pulse_q;
        num_d        = num_q;
        gap_d        = gap_q;
        last_state_d = last_state_q;
        z_count_d    = z_count_q;
        z_meta_d     = bus.z_in;
        z_s_d        = z_meta_q;
        z_dly_d      = z_s_q;
        z_rise       = z_s_q & ~z_dly_q;

        if (z_rise && (state_q == S_HIGH || state_q == S_GAP) && z_count_q != 8'hFF) begin
            z_count_d = z_count_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_CLEAR;
                    num_d     = bus.num_pulses;
                    gap_d     = (bus.gap == '0) ? GAP_BITS'(1) : bus.gap;
                    z_count_d = '0;
                    pulse_d   = '0;
                    cnt_d     = '0;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNT_W'(CLR_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (num_q == 8'd0) ? S_DONE : S_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == CNT_W'(PULSE_W - 1)) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(gap_q) - CNT_W'(1)) begin
                    cnt_d        = '0;
                    last_state_d = bus.y_in;
                    pulse_d      = pulse_q + 8'd1;
                    state_d      = (pulse_q + 8'd1 == num_q) ? S_DONE : S_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        x_out_d = (state_d == S_HIGH);
        rd_n_d  = (state_d == S_HIGH) || (state_d == S_GAP) || (state_d == S_DONE);
        busy_d  = (state_d == S_CLEAR) || (state_d == S_HIGH) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pulse_q      <= '0;
            num_q        <= '0;
            gap_q        <= '0;
            last_state_q <= '0;
            z_count_q    <= '0;
            z_meta_q     <= 1'b0;
            z_s_q        <= 1'b0;
            z_dly_q      <= 1'b0;
            x_out_q      <= 1'b0;
            rd_n_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
            num_q        <= num_d;
            gap_q        <= gap_d;
            last_state_q <= last_state_d;
            z_count_q    <= z_count_d;
            z_meta_q     <= z_meta_d;
            z_s_q        <= z_s_d;
            z_dly_q      <= z_dly_d;
            x_out_q      <= x_out_d;
            rd_n_q       <= rd_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.x_out      = x_out_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.z_count    = z_count_q;
    assign bus.last_state = last_state_q;
endmodule
